// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Package: cpu_pkg
//   ADDR_W / DATA_W : default address and instruction byte widths
//   LONG_OP_BIT     : opcode bit that marks a 2-byte instruction
//   PERF_W          : width of the optional performance counters
//   fetch_state_t   : fetch FSM state encoding
//   instr_t         : one decoded-instruction record {op, arg, pc, len}
package cpu_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int LONG_OP_BIT = 7;
  localparam int PERF_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OP    = 2'd1,
    S_ARG   = 2'd2,
    S_VALID = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] arg;
    logic [ADDR_W-1:0] pc;
    logic              len;
  } instr_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of every non-clock signal of the fetch stage.
// Groups:
//   PC       : pc_in (PC out), pc_en, pc_load, pc_next
//   memory   : mem_req, mem_addr, mem_ack, mem_rdata
//   execute  : redirect, redirect_addr
//   decode   : instr_valid, instr_ready, instr_op, instr_arg, instr_pc, instr_len
// Modports: master = fetch unit side, slave = PC/memory/execute/decode side.
//
// Handshakes:
//   memory : mem_req rises with mem_addr and both stay fixed until the cycle
//            with mem_req & mem_ack; that cycle carries mem_rdata and ends the
//            beat. mem_ack means nothing while mem_req is low.
//   decode : instr_* are stable while instr_valid is high; the instruction
//            transfers on the rising edge where instr_valid & instr_ready.
interface fetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic [ADDR_W-1:0] pc_in;
  logic              pc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_op;
  logic [DATA_W-1:0] instr_arg;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_len;

  modport master (
    input  pc_in, mem_ack, mem_rdata, redirect, redirect_addr, instr_ready,
    output pc_en, pc_load, pc_next, mem_req, mem_addr,
           instr_valid, instr_op, instr_arg, instr_pc, instr_len
  );

  modport slave (
    output pc_in, mem_ack, mem_rdata, redirect, redirect_addr, instr_ready,
    input  pc_en, pc_load, pc_next, mem_req, mem_addr,
           instr_valid, instr_op, instr_arg, instr_pc, instr_len
  );

endinterface

// File: rtl/fetch_unit_perf_ctr.sv
// Saturating event counter used by the optional fetch performance counters.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count clears to 0)
//   inc_i    : count one event this cycle
//   count_o  : current count, sticks at all-ones
module perf_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage wrapped around the program counter.
// Reads 1- or 2-byte instructions from memory (opcode bit 7 set = 2 bytes),
// steps the PC one byte per accepted memory beat, and offers each complete
// instruction to decode. A branch redirect from execute reloads the PC and
// drops whatever was being fetched or waiting for decode.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : fetch_unit_if.master (PC, memory, redirect, decode signals)
//   fetch_count : [FETCH_PERF_EN only] instructions handed to decode
//   stall_count : [FETCH_PERF_EN only] cycles waiting on memory ack
//   state_o     : current FSM state (debug)
// Build option: define FETCH_PERF_EN to add the two saturating counters.
module fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          bus,
`ifdef FETCH_PERF_EN
  output logic [15:0]           fetch_count,
  output logic [15:0]           stall_count,
`endif
  output cpu_pkg::fetch_state_t state_o
);

  import cpu_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] arg_q, arg_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              len_q, len_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;

  logic mem_req;
  logic pc_en;
  logic pc_load;
  logic instr_valid;
  logic redirect_take;

  // Redirect is ignored in S_IDLE so the PC reset has settled before any load.
  assign redirect_take = bus.redirect && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    ipc_d       = ipc_q;
    len_d       = len_q;
    pc_next_d   = pc_next_q;
    mem_req     = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_OP;
      end
      S_OP: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          pc_en   = 1'b1;
          op_d    = bus.mem_rdata;
          arg_d   = '0;
          ipc_d   = bus.pc_in;
          len_d   = bus.mem_rdata[LONG_OP_BIT];
          state_d = bus.mem_rdata[LONG_OP_BIT] ? S_ARG : S_VALID;
        end
      end
      S_ARG: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          pc_en   = 1'b1;
          arg_d   = bus.mem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (bus.instr_ready) begin
          state_d = S_OP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides everything above: any same-cycle ack or decode
    // acceptance is discarded and the instruction registers keep their value.
    if (redirect_take) begin
      mem_req     = 1'b0;
      pc_en       = 1'b0;
      instr_valid = 1'b0;
      pc_load     = 1'b1;
      pc_next_d   = bus.redirect_addr;
      op_d        = op_q;
      arg_d       = arg_q;
      ipc_d       = ipc_q;
      len_d       = len_q;
      state_d     = S_OP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      ipc_q     <= '0;
      len_q     <= 1'b0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      ipc_q     <= ipc_d;
      len_q     <= len_d;
      pc_next_q <= pc_next_d;
    end
  end

  // PC only moves on an ack, so pc_in is the stable fetch address.
  assign bus.mem_addr    = bus.pc_in;
  assign bus.mem_req     = mem_req;
  assign bus.pc_en       = pc_en;
  assign bus.pc_load     = pc_load;
  assign bus.pc_next     = redirect_take ? bus.redirect_addr : pc_next_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_op    = op_q;
  assign bus.instr_arg   = arg_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_len   = len_q;
  assign state_o         = state_q;

`ifdef FETCH_PERF_EN
  logic fetch_fire;
  logic stall_cycle;

  assign fetch_fire  = instr_valid & bus.instr_ready;
  assign stall_cycle = mem_req & ~bus.mem_ack;

  perf_ctr #(.W(PERF_W)) u_fetch_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (fetch_fire),
    .count_o (fetch_count)
  );

  perf_ctr #(.W(PERF_W)) u_stall_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_cycle),
    .count_o (stall_count)
  );
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: models the PC and a byte-wide memory
// with configurable wait states, drives decode/redirect, and checks outputs
// mid-cycle against hand-computed values.
module tb_fetch_unit;

  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  fetch_state_t dut_state;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef FETCH_PERF_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .state_o     (dut_state)
  );

  // ---------------- PC and memory models ----------------
  logic [7:0] pc_q;
  logic [7:0] mem [256];
  int         wait_cfg;
  int         wait_cnt;
  logic       force_ack;

  always @(posedge clk or posedge rst) begin
    if (rst)              pc_q <= 8'h00;
    else if (bus.pc_load) pc_q <= bus.pc_next;
    else if (bus.pc_en)   pc_q <= pc_q + 8'h01;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                               wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack)  wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
  end

  assign bus.pc_in     = pc_q;
  assign bus.mem_ack   = force_ack | (bus.mem_req & (wait_cnt >= wait_cfg));
  assign bus.mem_rdata = mem[bus.mem_addr];

  // ---------------- scoreboard ----------------
  instr_t got_q[$];
  instr_t exp_q[$];
  int     pc_en_cnt;
  int     overlap_cnt;
  int     vec_cnt;
  int     err_cnt;

  // Mid-cycle monitor: inputs only change on negedge, so +2 is settled.
  always begin
    instr_t cap;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.pc_en) pc_en_cnt++;
      if (bus.pc_en && bus.pc_load) overlap_cnt++;
      if (bus.instr_valid && bus.instr_ready) begin
        cap.op  = bus.instr_op;
        cap.arg = bus.instr_arg;
        cap.pc  = bus.instr_pc;
        cap.len = bus.instr_len;
        got_q.push_back(cap);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst               = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 8'h00;
    bus.instr_ready   = 1'b0;
    force_ack         = 1'b0;
    wait_cfg          = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    pc_en_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_addr = 8'h00;
    bus.instr_ready = 1'b0;
    force_ack = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.pc_en, bus.pc_load, bus.instr_valid} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {bus.mem_req, bus.pc_en, bus.pc_load, bus.instr_valid});
    end
    vec_cnt++;
    if ({bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len, bus.pc_next} !== 33'h0) begin
      err_cnt++;
      $display("FAIL reset_regs: op %h arg %h pc %h len %b pc_next %h expected all 0",
               bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len, bus.pc_next);
    end
    vec_cnt++;
    if (dut_state !== S_IDLE) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d expected %0d", dut_state, S_IDLE);
    end
  endtask

  task automatic test_one_byte();
    instr_t e;
    instr_t g;
    do_reset();
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    bus.instr_ready = 1'b1;
    e = '{op: 8'h01, arg: 8'h00, pc: 8'h00, len: 1'b0};
    exp_q.push_back(e);
    e = '{op: 8'h02, arg: 8'h00, pc: 8'h01, len: 1'b0};
    exp_q.push_back(e);
    #1;
    vec_cnt++;
    if (bus.mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL dead_cycle_req: got %b expected 0", bus.mem_req);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h00}) begin
      err_cnt++;
      $display("FAIL first_req: req %b addr %h expected 1 00", bus.mem_req, bus.mem_addr);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (got_q.size() >= 2) break;
    end
    vec_cnt++;
    if (got_q.size() !== 2) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d instrs expected 2", got_q.size());
    end
    vec_cnt++;
    if (pc_en_cnt !== 2) begin
      err_cnt++;
      $display("FAIL b2b_pc_en: got %0d pulses expected 2", pc_en_cnt);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vec_cnt++;
      if (g !== e) begin
        err_cnt++;
        $display("FAIL b2b_instr: got %h expected %h", g, e);
      end
    end
    @(negedge clk);
    bus.instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
    #1;
    vec_cnt++;
    if (fetch_count !== 16'd2) begin
      err_cnt++;
      $display("FAIL fetch_count: got %0d expected 2", fetch_count);
    end
`endif
  endtask

  task automatic test_two_byte();
    do_reset();
    mem[8'h10] = 8'h85;
    mem[8'h11] = 8'h3C;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'h10;
    @(negedge clk);
    bus.redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.instr_valid) break;
    end
    vec_cnt++;
    if ({bus.instr_valid, bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len}
        !== {1'b1, 8'h85, 8'h3C, 8'h10, 1'b1}) begin
      err_cnt++;
      $display("FAIL two_byte: valid %b op %h arg %h pc %h len %b expected 1 85 3c 10 1",
               bus.instr_valid, bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len);
    end
    vec_cnt++;
    if (pc_q !== 8'h12) begin
      err_cnt++;
      $display("FAIL two_byte_pc: got %h expected 12", pc_q);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    wait_cfg = 3;
    mem[0] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vec_cnt++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h00}) begin
        err_cnt++;
        $display("FAIL wait_req_hold[%0d]: req %b addr %h expected 1 00", i, bus.mem_req, bus.mem_addr);
      end
      vec_cnt++;
      if (bus.pc_en !== (i == 3)) begin
        err_cnt++;
        $display("FAIL wait_pc_en[%0d]: got %b expected %b", i, bus.pc_en, (i == 3));
      end
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.instr_valid, bus.instr_op, pc_q} !== {1'b1, 8'h05, 8'h01}) begin
      err_cnt++;
      $display("FAIL wait_result: valid %b op %h pc %h expected 1 05 01", bus.instr_valid, bus.instr_op, pc_q);
    end
`ifdef FETCH_PERF_EN
    vec_cnt++;
    if (stall_count !== 16'd3) begin
      err_cnt++;
      $display("FAIL stall_count: got %0d expected 3", stall_count);
    end
`endif
  endtask

  task automatic test_decode_stall();
    do_reset();
    mem[0] = 8'h07;
    mem[1] = 8'h08;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      vec_cnt++;
      if ({bus.instr_valid, bus.instr_op, bus.instr_pc, bus.mem_req} !== {1'b1, 8'h07, 8'h00, 1'b0}) begin
        err_cnt++;
        $display("FAIL stall_hold[%0d]: valid %b op %h pc %h req %b expected 1 07 00 0",
                 i, bus.instr_valid, bus.instr_op, bus.instr_pc, bus.mem_req);
      end
    end
    @(negedge clk);
    bus.instr_ready = 1'b1;
    #1;
    vec_cnt++;
    if (bus.mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_accept_req: got %b expected 0", bus.mem_req);
    end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.mem_addr, bus.instr_valid} !== {1'b1, 8'h01, 1'b0}) begin
      err_cnt++;
      $display("FAIL stall_resume: req %b addr %h valid %b expected 1 01 0",
               bus.mem_req, bus.mem_addr, bus.instr_valid);
    end
    vec_cnt++;
    if (got_q.size() !== 1) begin
      err_cnt++;
      $display("FAIL stall_accept_count: got %0d expected 1", got_q.size());
    end
  endtask

  task automatic test_redirect_squash();
    do_reset();
    mem[0] = 8'h85;
    mem[1] = 8'h11;
    mem[8'h40] = 8'h22;
    @(negedge clk);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'h40;
    force_ack = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.pc_load, bus.pc_next, bus.pc_en, bus.mem_req, bus.instr_valid}
        !== {1'b1, 8'h40, 1'b0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL redirect_cycle: load %b next %h en %b req %b valid %b expected 1 40 0 0 0",
               bus.pc_load, bus.pc_next, bus.pc_en, bus.mem_req, bus.instr_valid);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    force_ack = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.mem_addr, bus.pc_next, bus.instr_valid, pc_q}
        !== {1'b1, 8'h40, 8'h40, 1'b0, 8'h40}) begin
      err_cnt++;
      $display("FAIL redirect_refetch: req %b addr %h next %h valid %b pc %h expected 1 40 40 0 40",
               bus.mem_req, bus.mem_addr, bus.pc_next, bus.instr_valid, pc_q);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.instr_valid, bus.instr_op, bus.instr_pc, bus.instr_len} !== {1'b1, 8'h22, 8'h40, 1'b0}) begin
      err_cnt++;
      $display("FAIL redirect_target: valid %b op %h pc %h len %b expected 1 22 40 0",
               bus.instr_valid, bus.instr_op, bus.instr_pc, bus.instr_len);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem[8'hFF] = 8'h90;
    mem[8'h00] = 8'h5A;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'hFF;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h00}) begin
      err_cnt++;
      $display("FAIL wrap_arg_addr: req %b addr %h expected 1 00", bus.mem_req, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.instr_valid, bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len, pc_q}
        !== {1'b1, 8'h90, 8'h5A, 8'hFF, 1'b1, 8'h01}) begin
      err_cnt++;
      $display("FAIL wrap_instr: valid %b op %h arg %h pc %h len %b pcreg %h expected 1 90 5a ff 1 01",
               bus.instr_valid, bus.instr_op, bus.instr_arg, bus.instr_pc, bus.instr_len, pc_q);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem[0] = 8'h90;
    mem[1] = 8'h33;
    @(negedge clk);
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.instr_op} !== {1'b1, 8'h90}) begin
      err_cnt++;
      $display("FAIL arst_setup: req %b op %h expected 1 90", bus.mem_req, bus.instr_op);
    end
    #1;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.mem_req, bus.pc_en, bus.pc_load, bus.instr_valid, bus.instr_op, bus.instr_len}
        !== {4'b0000, 8'h00, 1'b0}) begin
      err_cnt++;
      $display("FAIL arst_outputs: req %b en %b load %b valid %b op %h len %b expected all 0",
               bus.mem_req, bus.pc_en, bus.pc_load, bus.instr_valid, bus.instr_op, bus.instr_len);
    end
    vec_cnt++;
    if (dut_state !== S_IDLE) begin
      err_cnt++;
      $display("FAIL arst_state: got %0d expected %0d", dut_state, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    pc_en_cnt   = 0;
    overlap_cnt = 0;
    rst         = 1'b1;
    test_reset();
    test_one_byte();
    test_two_byte();
    test_wait_states();
    test_decode_stall();
    test_redirect_squash();
    test_wrap();
    test_async_reset();
    vec_cnt++;
    if (overlap_cnt !== 0) begin
      err_cnt++;
      $display("FAIL pc_en_load_exclusive: got %0d overlapping cycles expected 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
